// File: rtl/p18_sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module : p18_sprite_pkg
// Brief  : Shared types and helpers for the p18 sprite buffer.
// Rev    : 1.0 - initial release
// ============================================================================
package p18_sprite_pkg;

    // Load port state
    typedef enum logic [0:0] {
        LD_IDLE = 1'b0,
        LD_LOAD = 1'b1
    } ld_state_t;

    // Address width needed to index a w x h sprite (never below 1 bit)
    function automatic int sprite_addr_w(input int w, input int h);
        int n;
        n = w * h;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : p18_sprite_pkg
`default_nettype wire

// File: rtl/p18_sprite_scan.sv
`default_nettype none
// ============================================================================
// Module : p18_sprite_scan
// Brief  : Raster counters, flip flags, busy flag and read-address generator.
// Rev    : 1.0 - initial release
// ============================================================================
module p18_sprite_scan #(
    parameter int WIDTH  = 12,
    parameter int HEIGHT = 12,
    parameter int AW     = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          frame_start,
    input  logic          flip_x,
    input  logic          flip_y,
    input  logic          pix_en,
    output logic          busy,
    output logic [AW-1:0] addr
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    localparam logic [XW-1:0] c_XMAX   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] c_YMAX   = YW'(HEIGHT - 1);
    localparam logic [AW-1:0] c_XMAX_A = AW'(WIDTH - 1);
    localparam logic [AW-1:0] c_YMAX_A = AW'(HEIGHT - 1);
    localparam logic [AW-1:0] c_W_A    = AW'(WIDTH);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_fx;
    logic          r_fy;
    logic          r_busy;

    logic [AW-1:0] w_row;
    logic [AW-1:0] w_col;

    // Raster position: frame_start restarts and latches flips, pix_en walks the sprite
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_fx   <= 1'b0;
            r_fy   <= 1'b0;
            r_busy <= 1'b0;
        end else if (frame_start) begin
            r_x    <= '0;
            r_y    <= '0;
            r_fx   <= flip_x;
            r_fy   <= flip_y;
            r_busy <= 1'b1;
        end else if (pix_en && r_busy) begin
            if (r_x == c_XMAX) begin
                r_x <= '0;
                if (r_y == c_YMAX) begin
                    r_y    <= '0;
                    r_busy <= 1'b0;
                end else begin
                    r_y <= r_y + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Mirrored row/column folded into a row-major address; WIDTH-1-x never underflows
    always_comb begin
        w_row = r_fy ? (c_YMAX_A - AW'(r_y)) : AW'(r_y);
        w_col = r_fx ? (c_XMAX_A - AW'(r_x)) : AW'(r_x);
        addr  = w_row * c_W_A + w_col;
    end

    assign busy = r_busy;

endmodule : p18_sprite_scan
`default_nettype wire

// File: rtl/p18_sprite_buffer.sv
`default_nettype none
// ============================================================================
// Module : p18_sprite_buffer
// Brief  : Multi-bit sprite store with flipped raster readout and a
//          valid/ready serial load port.
// Rev    : 1.0 - initial release
// ============================================================================
module p18_sprite_buffer
    import p18_sprite_pkg::*;
#(
    parameter int                            WIDTH  = 12,
    parameter int                            HEIGHT = 12,
    parameter int                            BPP    = 2,
    parameter logic [WIDTH*HEIGHT*BPP-1:0]   INIT   = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           frame_start,
    input  logic           flip_x,
    input  logic           flip_y,
    input  logic           pix_en,
    output logic [BPP-1:0] pix_out,
    output logic           busy,
    input  logic           load_start,
    input  logic           load_valid,
    input  logic [BPP-1:0] load_data,
    output logic           load_ready,
    output logic           load_done
);

    localparam int c_N  = WIDTH * HEIGHT;
    localparam int c_AW = sprite_addr_w(WIDTH, HEIGHT);

    localparam logic [c_AW-1:0] c_LAST = c_AW'(c_N - 1);

    // Packed so the reset image maps straight onto the storage layout
    logic [c_N-1:0][BPP-1:0] r_mem;

    ld_state_t       r_state;
    ld_state_t       w_state_next;
    logic [c_AW-1:0] r_waddr;
    logic [c_AW-1:0] w_waddr_next;
    logic            r_load_done;
    logic            w_load_done_next;
    logic            w_we;
    logic [c_AW-1:0] w_raddr;

    p18_sprite_scan #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .AW     (c_AW)
    ) u_scan (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .flip_x      (flip_x),
        .flip_y      (flip_y),
        .pix_en      (pix_en),
        .busy        (busy),
        .addr        (w_raddr)
    );

    // Load FSM state, write pointer and done pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= LD_IDLE;
            r_waddr     <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_waddr     <= w_waddr_next;
            r_load_done <= w_load_done_next;
        end
    end

    // Load FSM next state; a restart rewinds the pointer but keeps written pixels
    always_comb begin
        w_state_next     = r_state;
        w_waddr_next     = r_waddr;
        w_load_done_next = 1'b0;
        load_ready       = 1'b0;
        case (r_state)
            LD_IDLE: begin
                if (load_start) begin
                    w_state_next = LD_LOAD;
                    w_waddr_next = '0;
                end
            end
            LD_LOAD: begin
                load_ready = 1'b1;
                if (load_start) begin
                    w_waddr_next = '0;
                end else if (load_valid) begin
                    if (r_waddr == c_LAST) begin
                        w_state_next     = LD_IDLE;
                        w_waddr_next     = '0;
                        w_load_done_next = 1'b1;
                    end else begin
                        w_waddr_next = r_waddr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = LD_IDLE;
            end
        endcase
    end

    assign w_we = load_valid && (r_state == LD_LOAD);

    // Sprite storage: reset restores the boot image, accepted beats overwrite one pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= INIT;
        end else if (w_we) begin
            r_mem[r_waddr] <= load_data;
        end
    end

    // Half-written images are hidden behind transparency until the load ends
    always_comb begin
        pix_out = (r_state == LD_LOAD) ? '0 : r_mem[w_raddr];
    end

    assign load_done = r_load_done;

endmodule : p18_sprite_buffer
`default_nettype wire

// File: tb/tb_p18_sprite_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_p18_sprite_buffer
// Brief  : Self-checking bench for p18_sprite_buffer (4x2 sprite, 2 bpp).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_p18_sprite_buffer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;
    localparam logic [15:0] c_INIT = 16'h1BE4; // pixels 0,1,2,3,3,2,1,0

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0, flip_x = 1'b0, flip_y = 1'b0, pix_en = 1'b0;
    logic       load_start = 1'b0, load_valid = 1'b0;
    logic [1:0] load_data = 2'd0;
    logic [1:0] pix_out;
    logic       busy, load_ready, load_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (frame position kept as a linear pixel count)
    logic [1:0] m_mem [N];
    int         m_k;
    bit         m_busy, m_fx, m_fy, m_loading, m_done;
    int         m_waddr;

    p18_sprite_buffer #(
        .WIDTH  (W),
        .HEIGHT (H),
        .BPP    (2),
        .INIT   (c_INIT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .flip_x      (flip_x),
        .flip_y      (flip_y),
        .pix_en      (pix_en),
        .pix_out     (pix_out),
        .busy        (busy),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        logic [15:0] img;
        img = c_INIT;
        for (int i = 0; i < N; i++) m_mem[i] = img[i*2 +: 2];
        m_k = 0; m_busy = 0; m_fx = 0; m_fy = 0;
        m_loading = 0; m_done = 0; m_waddr = 0;
    endfunction

    // Expected visible pixel: k-th pixel in raster order of the mirrored image
    function automatic logic [1:0] exp_pix();
        int x, y;
        if (m_loading) return 2'd0;
        x = m_k % W;
        y = m_k / W;
        if (m_fx) x = W - 1 - x;
        if (m_fy) y = H - 1 - y;
        return m_mem[y*W + x];
    endfunction

    // One clock: apply inputs, advance the model at the edge, settle before sampling
    task automatic cyc(input bit fs, input bit flx, input bit fly, input bit pe,
                       input bit ls, input bit lv, input logic [1:0] ld);
        frame_start = fs; flip_x = flx; flip_y = fly; pix_en = pe;
        load_start = ls; load_valid = lv; load_data = ld;
        @(posedge clk);
        m_done = 0;
        if (m_loading && lv) m_mem[m_waddr] = ld;
        if (ls) begin
            m_loading = 1; m_waddr = 0;
        end else if (m_loading && lv) begin
            if (m_waddr == N - 1) begin
                m_loading = 0; m_waddr = 0; m_done = 1;
            end else begin
                m_waddr++;
            end
        end
        if (fs) begin
            m_k = 0; m_fx = flx; m_fy = fly; m_busy = 1;
        end else if (pe && m_busy) begin
            m_k++;
            if (m_k == N) begin
                m_k = 0; m_busy = 0;
            end
        end
        #1;
        frame_start = 0; pix_en = 0; load_start = 0; load_valid = 0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (pix_out !== 2'd0) begin n_fail++; $display("FAIL reset_pix got %0d want 0", pix_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", load_ready); end
        n_checks++;
        if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", load_done); end
    endtask

    // Reads one full frame, comparing against a fixed sequence and the model
    task automatic read_frame(input string tag, input bit flx, input bit fly,
                              input logic [1:0] seq [N], input bit use_seq);
        cyc(1, flx, fly, 0, 0, 0, 2'd0);
        for (int i = 0; i <= N; i++) begin
            logic [1:0] want;
            want = (i == N) ? seq[0] : seq[i];
            if (!use_seq) want = exp_pix();
            n_checks++;
            if (pix_out !== want || pix_out !== exp_pix()) begin
                n_fail++;
                $display("FAIL %s_pix[%0d] got %0d want %0d", tag, i, pix_out, want);
            end
            n_checks++;
            if (busy !== (i < N)) begin
                n_fail++;
                $display("FAIL %s_busy[%0d] got %0b want %0b", tag, i, busy, (i < N));
            end
            if (i < N) cyc(0, 0, 0, 1, 0, 0, 2'd0);
        end
    endtask

    task automatic test_reset_readout();
        logic [1:0] seq [N] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        read_frame("readout", 0, 0, seq, 1);
    endtask

    task automatic test_flip();
        logic [1:0] seq_xy [N] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        logic [1:0] seq_x  [N] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [1:0] seq_y  [N] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        read_frame("flipxy", 1, 1, seq_xy, 1);
        read_frame("flipx", 1, 0, seq_x, 1);
        read_frame("flipy", 0, 1, seq_y, 1);
    endtask

    task automatic test_load_stall();
        logic [1:0] seq [N] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        int dones;
        dones = 0;
        cyc(0, 0, 0, 0, 1, 0, 2'd0);
        for (int b = 0; b < N; b++) begin
            n_checks++;
            if (load_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready[%0d] got %0b want 1", b, load_ready); end
            cyc(0, 0, 0, 0, 0, 0, 2'd0);
            n_checks++;
            if (load_ready !== 1'b1) begin n_fail++; $display("FAIL stall_gap_ready[%0d] got %0b want 1", b, load_ready); end
            cyc(0, 0, 0, 0, 0, 1, 2'd2);
            if (load_done) dones++;
            n_checks++;
            if (load_done !== (b == N - 1)) begin
                n_fail++;
                $display("FAIL stall_done[%0d] got %0b want %0b", b, load_done, (b == N - 1));
            end
        end
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_end got %0b want 0", load_ready); end
        cyc(0, 0, 0, 0, 0, 1, 2'd1); // ignored in IDLE
        if (load_done) dones++;
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL stall_done_count got %0d want 1", dones); end
        read_frame("stall_read", 0, 0, seq, 1);
    endtask

    task automatic test_load_restart();
        int dones;
        dones = 0;
        cyc(0, 0, 0, 0, 1, 0, 2'd0);
        for (int b = 0; b < 3; b++) cyc(0, 0, 0, 0, 0, 1, 2'($urandom));
        cyc(1, 0, 0, 0, 0, 0, 2'd0);
        n_checks++;
        if (pix_out !== 2'd0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL restart_transp got pix=%0d busy=%0b want pix=0 busy=1", pix_out, busy);
        end
        cyc(0, 0, 0, 1, 1, 0, 2'd0);
        n_checks++;
        if (pix_out !== 2'd0) begin n_fail++; $display("FAIL restart_transp2 got %0d want 0", pix_out); end
        for (int guard = 0; guard < 200 && m_loading; guard++) begin
            cyc(0, 0, 0, $urandom_range(0, 1), 0, $urandom_range(0, 1), 2'($urandom));
            if (load_done) dones++;
            n_checks++;
            if (pix_out !== exp_pix()) begin n_fail++; $display("FAIL restart_pix got %0d want %0d", pix_out, exp_pix()); end
        end
        cyc(0, 0, 0, 0, 0, 0, 2'd0);
        if (load_done) dones++;
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL restart_done_count got %0d want 1", dones); end
        begin
            logic [1:0] unused [N];
            unused = m_mem;
            read_frame("restart_read", $urandom_range(0, 1), $urandom_range(0, 1), unused, 0);
        end
    endtask

    task automatic test_collision();
        logic [1:0] held;
        cyc(1, 0, 0, 1, 0, 0, 2'd0);
        n_checks++;
        if (pix_out !== m_mem[0] || busy !== 1'b1) begin
            n_fail++; $display("FAIL collide_first got pix=%0d busy=%0b want pix=%0d busy=1", pix_out, busy, m_mem[0]);
        end
        cyc(0, 0, 0, 1, 0, 0, 2'd0);
        n_checks++;
        if (pix_out !== m_mem[1]) begin n_fail++; $display("FAIL collide_second got %0d want %0d", pix_out, m_mem[1]); end
        for (int i = 0; i < N - 1; i++) cyc(0, 0, 0, 1, 0, 0, 2'd0);
        held = exp_pix();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 0, 2'd0);
            n_checks++;
            if (pix_out !== held || busy !== 1'b0) begin
                n_fail++; $display("FAIL idle_pix_en got pix=%0d busy=%0b want pix=%0d busy=0", pix_out, busy, held);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cyc($urandom_range(0, 29) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 59) == 0, $urandom_range(0, 1), 2'($urandom));
            n_checks++;
            if (pix_out !== exp_pix() || busy !== m_busy || load_ready !== m_loading || load_done !== m_done) begin
                n_fail++;
                $display("FAIL random[%0d] got pix=%0d busy=%0b rdy=%0b done=%0b want pix=%0d busy=%0b rdy=%0b done=%0b",
                         c, pix_out, busy, load_ready, load_done, exp_pix(), m_busy, m_loading, m_done);
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(0, 0, 0, 0, 1, 0, 2'd0);
        for (int b = 0; b < 4; b++) cyc(0, 0, 0, 0, 0, 1, 2'd1);
        cyc(1, 0, 0, 1, 0, 0, 2'd0);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (load_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got rdy=%0b busy=%0b done=%0b want 0 0 0", load_ready, busy, load_done);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        model_reset();
        test_reset_readout();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        test_reset();
        test_reset_readout();
        test_flip();
        test_load_stall();
        test_load_restart();
        test_collision();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_p18_sprite_buffer
`default_nettype wire

// File: doc/p18_sprite_buffer.md
# p18_sprite_buffer

Parametrised, addressable sprite store for the p18 video pipeline. It replaces the fixed 1-bit rotating sprite shift register with a multi-bit-per-pixel RAM-style array, and adds:
- raster readout with per-frame horizontal/vertical flip;
- a valid/ready serial load port for swapping sprite images at run time.

It sits between the sprite position comparator, which drives `frame_start`/`pix_en`, and the palette/colour mixer, which consumes `pix_out`.

## Interface

Parameters:
- `WIDTH`, default 12, sprite width in pixels (≥2).
- `HEIGHT`, default 12, sprite height in pixels (≥2).
- `BPP`, default 2, bits per pixel. Value 0 is transparent/background.
- `INIT`, default '0, `WIDTH*HEIGHT*BPP` bits. Reset image: pixel i (row-major, i = y*WIDTH+x) is `INIT[i*BPP +: BPP]`.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: one-cycle pulse; restart readout at the sprite's first pixel.
- `flip_x` in 1: mirror horizontally; sampled on `frame_start`.
- `flip_y` in 1: mirror vertically; sampled on `frame_start`.
- `pix_en` in 1: advance readout by one pixel.
- `pix_out` out BPP: current pixel value.
- `busy` out 1: readout in progress.
- `load_start` in 1: one-cycle pulse; begin image load.
- `load_valid` in 1: load data valid.
- `load_data` in BPP: load pixel.
- `load_ready` out 1: block accepts a load beat.
- `load_done` out 1: one-cycle pulse after the last beat is written.

## Operation

- Storage: `N = WIDTH*HEIGHT` entries of BPP bits. Reset loads `INIT`; no other reset clears storage.
- Readout counters: `x` in [0, WIDTH-1], `y` in [0, HEIGHT-1]. Registered flags `fx` and `fy`.
- Read address: `(fy ? HEIGHT-1-y : y)*WIDTH + (fx ? WIDTH-1-x : x)`. `pix_out` is a combinational read of that address.
- `frame_start`: x=0, y=0, `fx`=`flip_x`, `fy`=`flip_y`, `busy`=1.
- `pix_en` while `busy`:
  - x increments.
  - At x=WIDTH-1: x wraps to 0 and y increments.
  - At the last pixel (x=WIDTH-1, y=HEIGHT-1): counters wrap to 0 and `busy` drops.
- `pix_en` while not `busy`: ignored.
- `frame_start` and `pix_en` in the same cycle: `frame_start` wins and `pix_en` is dropped.
- Load FSM has two states, IDLE and LOAD:
  - IDLE→LOAD on `load_start`; `waddr` is set to 0.
  - In LOAD, `load_ready`=1. Each `load_valid && load_ready` cycle writes `load_data` to `mem[waddr]`, then `waddr` increments.
  - The beat at `waddr = N-1` moves the FSM to IDLE and pulses `load_done` in the next cycle.
  - `load_start` while in LOAD restarts at `waddr` 0. Already-written entries are kept.
  - `load_valid` in IDLE is ignored.
- While in LOAD, `pix_out` is forced to 0 (transparent). Readout counters keep advancing normally.
- Reset values: `pix_out`=INIT pixel 0, `busy`=0, `load_ready`=0, `load_done`=0, state IDLE, x=y=0, `fx`=`fy`=0, `waddr`=0.

## Timing

- `pix_out` reflects counter state with zero cycles of latency: the value after `frame_start` in cycle t is valid in cycle t+1.
- A write in cycle t is visible on `pix_out` from cycle t+1 if addresses match. `pix_out` stays 0 until LOAD exits.
- `load_done` is high in the cycle after the final handshake. `load_ready` is 0 in that same cycle.
- Reset asserted mid-load or mid-readout: all registers, including storage, return to reset values asynchronously.
- Counter widths: `$clog2(WIDTH)`, `$clog2(HEIGHT)`, `$clog2(N)`. Address arithmetic is unsigned at `$clog2(N)` bits. There is no overflow because WIDTH-1-x ≥ 0.

## Structure

- Package `p18_sprite_pkg`: load state enum (`LD_IDLE`, `LD_LOAD`) and a `sprite_addr_w(w,h)` helper function.
- Sub-module `p18_sprite_scan`: x/y counters, flip flags, `busy` and address generation. Storage and the load FSM stay in the top module.

## Test plan

- **Reset readout:** WIDTH=4, HEIGHT=2, BPP=2, INIT pixels 0..7 = 0,1,2,3,3,2,1,0. Pulse `frame_start`, then 8 × `pix_en` → `pix_out` 0,1,2,3,3,2,1,0. `busy` falls after the 8th `pix_en`.
- **Flip:** same config, `flip_x`=1, `flip_y`=1 at `frame_start` → `pix_out` 0,1,2,3,3,2,1,0 read reversed per address, i.e. pixel 7..0. `flip_x` only → 3,2,1,0,0,1,2,3.
- **Load with stalls:** `load_start`, then 8 beats of value 2 with `load_valid` deasserted every other cycle. Expect `load_ready` high throughout and `load_done` exactly once, one cycle after beat 8. Subsequent readout is all 2.
- **Load restart and transparency:** `load_start` after 3 beats; readout during LOAD gives `pix_out`=0. Complete 8 beats → total `load_done` count is 1.
- **Collision:** `frame_start` and `pix_en` in the same cycle → x=y=0, first pixel shown. `pix_en` while idle → `pix_out` unchanged.
- **Async reset mid-load:** drop `reset_n` after 4 beats → `load_ready`=0 immediately, storage restored to INIT, readout matches the reset readout scenario.
